snn_img_ctrl: RTL

Top-level sequencer that owns the SNN inference flow. It receives a 784-pixel binary image as 98 packed bytes from the UART receiver and holds it in an internal pixel buffer. It serves the buffer to the SNN core's `q_input` port, pulses the core's `start`, and waits for `done`. It then captures the classified digit and hands an ASCII result byte to the UART transmitter before returning to image load.

---
 rtl/snn_img_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/snn_img_ctrl.sv
// snn_img_ctrl: inference sequencer for the SNN digit classifier.
// It collects a packed binary image from the UART receiver into a pixel
// buffer and serves that buffer to the SNN core. It starts the core, waits
// for its classification, and hands an ASCII result byte to the UART
// transmitter.
//
// state  | meaning
// -------+--------------------------------------------------------------
// LOAD   | accepting image bytes from rx; busy low
// START  | one-cycle core_start pulse is being presented to the core
// WAIT   | core running; waiting for core_done to capture the digit
// SEND   | result captured; waiting for tx_busy low to request transmit
module snn_img_ctrl #(
  parameter int         NUM_BYTES  = 98,
  parameter int         NUM_PIXELS = 784,
  parameter logic [7:0] ASCII_BASE = 8'h30,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic [9:0] core_addr,
  output logic       q_input,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [3:0] digit,
  output logic       result_valid,
  output logic       busy,
  output logic       ovr
);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_SEND} state_t;

  localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);
  localparam logic [9:0] PIX_LIMIT = 10'(NUM_PIXELS);

  state_t                state;
  logic [6:0]            byte_cnt;
  logic [NUM_PIXELS-1:0] pix_buf;
  logic [9:0]            wr_base;
  logic [7:0]            result_char;
  logic                  load_wr;

  // Byte k lands on pixels 8k..8k+7, LSB first.
  assign wr_base = {byte_cnt, 3'b000};
  assign load_wr = (state == S_LOAD) && rx_rdy;

  // Out-of-range digits are reported as a distinct marker character.
  assign result_char = (core_digit <= 4'd9) ? (ASCII_BASE + {4'h0, core_digit}) : BAD_CHAR;

  // Pixel buffer write; contents persist until overwritten by the next image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_buf <= '0;
    end else if (load_wr) begin
      pix_buf[wr_base +: 8] <= rx_data;
    end
  end

  // Registered pixel read to match the core's one-cycle weight-ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_input <= 1'b0;
    end else if (core_addr < PIX_LIMIT) begin
      q_input <= pix_buf[core_addr];
    end else begin
      q_input <= 1'b0;
    end
  end

  // Sequencer FSM with registered pulse and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_LOAD;
      byte_cnt     <= '0;
      core_start   <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      digit        <= 4'h0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      core_start <= 1'b0;
      tx_start   <= 1'b0;

      // Bytes arriving while an inference is in flight are dropped.
      if (rx_rdy && (state != S_LOAD)) begin
        ovr <= 1'b1;
      end

      case (state)
        S_LOAD: begin
          if (rx_rdy) begin
            if (byte_cnt == '0) begin
              result_valid <= 1'b0;
              ovr          <= 1'b0;
            end
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt   <= '0;
              state      <= S_START;
              core_start <= 1'b1;
              busy       <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            digit        <= core_digit;
            result_valid <= 1'b1;
            tx_data      <= result_char;
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            busy     <= 1'b0;
            state    <= S_LOAD;
          end
        end
        default: begin
          state <= S_LOAD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
